// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Control, load and instruction bus of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if #(
   parameter int ADDR_W = 5
);
   import inst_fetch_pkg::*;

   logic              Start;
   logic              Abort;
   logic              LoadEn;
   logic [ADDR_W-1:0] LoadAddr;
   logic [INST_W-1:0] LoadData;
   logic [ADDR_W:0]   ProgLen;
   logic              Stall;
   logic              JumpEn;
   logic [ADDR_W-1:0] JumpAddr;
   logic [INST_W-1:0] Inst;
   logic              InstValid;
   logic [ADDR_W:0]   PC;
   logic              Busy;
   logic              Done;

   modport master (
      output Start, Abort, LoadEn, LoadAddr, LoadData, ProgLen,
             Stall, JumpEn, JumpAddr,
      input  Inst, InstValid, PC, Busy, Done
   );

   modport slave (
      input  Start, Abort, LoadEn, LoadAddr, LoadData, ProgLen,
             Stall, JumpEn, JumpAddr,
      output Inst, InstValid, PC, Busy, Done
   );

endinterface
`default_nettype wire

// File: rtl/inst_mem.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem
// Description : DEPTH x DATA_W program memory, one write port, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int DATA_W = INST_W
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_we,
   input  wire logic [ADDR_W-1:0] i_waddr,
   input  wire logic [DATA_W-1:0] i_wdata,
   input  wire logic              i_re,
   input  wire logic [ADDR_W-1:0] i_raddr,
   input  wire logic              i_clr,
   output logic      [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read register doubles as the stage output, so clear inserts a NOP bubble.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_rdata <= NOP_INST;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Program memory, PC and run-control FSM feeding the Controller.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input wire logic   clk,
   input wire logic   rst,
   inst_fetch_if.slave bus
);
   import inst_fetch_pkg::*;

   localparam logic [ADDR_W:0] C_LEN_MAX = (ADDR_W+1)'(DEPTH);

   fetch_state_t      r_state;
   logic [ADDR_W:0]   r_pc;
   logic [ADDR_W:0]   r_len;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;

   logic              w_in_run;
   logic              w_loadable;
   logic              w_at_end;
   logic              w_we;
   logic              w_re;
   logic              w_clr;
   logic [ADDR_W:0]   w_len_clamped;
   logic [INST_W-1:0] w_inst;

   assign w_in_run      = (r_state == ST_RUN);
   assign w_loadable    = (r_state == ST_IDLE) || (r_state == ST_HALT);
   assign w_at_end      = (r_pc >= r_len);
   assign w_len_clamped = (bus.ProgLen > C_LEN_MAX) ? C_LEN_MAX : bus.ProgLen;

   assign w_we  = w_loadable && bus.LoadEn && !bus.Abort && !rst;
   assign w_re  = w_in_run && !bus.Abort && !bus.JumpEn && !bus.Stall && !w_at_end;
   // Bubble on abort, on a jump (even when stalled) and on the halting cycle.
   assign w_clr = bus.Abort ||
                  (w_in_run && (bus.JumpEn || (!bus.Stall && w_at_end)));

   inst_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (INST_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (bus.LoadAddr),
      .i_wdata (bus.LoadData),
      .i_re    (w_re),
      .i_raddr (r_pc[ADDR_W-1:0]),
      .i_clr   (w_clr),
      .o_rdata (w_inst)
   );

   always_ff @(posedge clk) begin
      if (rst || bus.Abort) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_len   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (bus.Start) begin
                  r_state <= ST_RUN;
                  r_pc    <= '0;
                  r_len   <= w_len_clamped;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (bus.JumpEn) begin
                  r_pc    <= {1'b0, bus.JumpAddr};
                  r_valid <= 1'b0;
               end else if (bus.Stall) begin
                  r_pc    <= r_pc;
               end else if (w_at_end) begin
                  r_state <= ST_HALT;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_pc    <= r_pc + 1'b1;
                  r_valid <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Inst      = w_inst;
   assign bus.InstValid = r_valid;
   assign bus.PC        = r_pc;
   assign bus.Busy      = r_busy;
   assign bus.Done      = r_done;

endmodule
`default_nettype wire
